// File: rtl/hamm_decoder.sv
// Purpose: Hamming (8,4) decoder, corrects single-bit errors, flags uncorrectable words.
// Latency: 2 cycles from accepted input to out_valid; throughput 1 word/cycle.
// Backpressure: valid/ready both sides; with out_ready low both stages fill, then in_ready drops.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-low reset
//   in_code          received codeword {d3,d2,d1,d0,p3,p2,p1,p0}, qualified by in_valid/in_ready
//   out_data         corrected data {d3,d2,d1,d0} (raw data bits when out_uncorr=1)
//   out_corr         a single data or parity bit was corrected
//   out_uncorr       syndrome of weight 2 or 4, data not corrected
//   out_valid/ready  output handshake
//   stat_clr         synchronous clear of the statistics counters
//   corr_cnt         saturating count of accepted words with out_corr=1
//   uncorr_cnt       saturating count of accepted words with out_uncorr=1
//
// Build option: define HAMM_DEC_STATS_EN to build the statistics counters.
// Without it corr_cnt/uncorr_cnt read 0 and stat_clr is ignored.

module hamm_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_code,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       out_data,
  output logic             out_corr,
  output logic             out_uncorr,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  // ---------------------------------------------------------------------------
  // Syndrome of the incoming codeword (computed ahead of stage 1)
  // ---------------------------------------------------------------------------
  logic [3:0] rx_data;
  logic [3:0] rx_par;
  logic [3:0] calc_par;
  logic [3:0] syn;

  always_comb begin
    rx_data     = in_code[7:4];
    rx_par      = in_code[3:0];
    calc_par[3] = rx_data[3] ^ rx_data[2] ^ rx_data[1];
    calc_par[2] = rx_data[3] ^ rx_data[2] ^ rx_data[0];
    calc_par[1] = rx_data[3] ^ rx_data[1] ^ rx_data[0];
    calc_par[0] = rx_data[2] ^ rx_data[1] ^ rx_data[0];
    syn         = rx_par ^ calc_par;
  end

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic       s1_valid_q, s1_valid_d;
  logic [7:0] s1_code_q,  s1_code_d;
  logic [3:0] s1_syn_q,   s1_syn_d;

  logic       out_valid_q,  out_valid_d;
  logic [3:0] out_data_q,   out_data_d;
  logic       out_corr_q,   out_corr_d;
  logic       out_uncorr_q, out_uncorr_d;

  logic s1_load;
  logic s2_load;
  logic out_fire;

  // in_ready depends only on state and out_ready, never on in_valid, so an
  // upstream that waits for ready before raising valid cannot form a loop.
  always_comb begin
    in_ready = ~s1_valid_q | ~out_valid_q | out_ready;
    s1_load  = in_valid & in_ready;
    s2_load  = s1_valid_q & (~out_valid_q | out_ready);
    out_fire = out_valid_q & out_ready;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: hold the raw codeword together with its syndrome
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_code_d  = in_code;
      s1_syn_d   = syn;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 decode. Weight-3 syndromes name the one data bit that took part in
  // all three failing checks; weight-1 syndromes are a lone parity bit, which
  // leaves the data intact. Weight 2 and 4 cannot come from one flipped bit.
  // ---------------------------------------------------------------------------
  logic [3:0] flip_mask;
  logic [3:0] dec_data;
  logic       dec_corr;
  logic       dec_uncorr;

  always_comb begin
    flip_mask  = 4'b0000;
    dec_corr   = 1'b0;
    dec_uncorr = 1'b0;
    case (s1_syn_q)
      4'b0000: flip_mask = 4'b0000;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: dec_corr = 1'b1;
      4'b1110: begin
        flip_mask = 4'b1000;
        dec_corr  = 1'b1;
      end
      4'b1101: begin
        flip_mask = 4'b0100;
        dec_corr  = 1'b1;
      end
      4'b1011: begin
        flip_mask = 4'b0010;
        dec_corr  = 1'b1;
      end
      4'b0111: begin
        flip_mask = 4'b0001;
        dec_corr  = 1'b1;
      end
      default: dec_uncorr = 1'b1;
    endcase
    dec_data = s1_code_q[7:4] ^ flip_mask;
  end

  // Output register only moves on s2_load, so out_* hold while stalled.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_corr_d   = out_corr_q;
    out_uncorr_d = out_uncorr_q;
    if (s2_load) begin
      out_valid_d  = 1'b1;
      out_data_d   = dec_data;
      out_corr_d   = dec_corr;
      out_uncorr_d = dec_uncorr;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q   <= 1'b0;
      s1_code_q    <= 8'h00;
      s1_syn_q     <= 4'h0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 4'h0;
      out_corr_q   <= 1'b0;
      out_uncorr_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_code_q    <= s1_code_d;
      s1_syn_q     <= s1_syn_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_corr_q   <= out_corr_d;
      out_uncorr_q <= out_uncorr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_corr   = out_corr_q;
  assign out_uncorr = out_uncorr_q;

  // ---------------------------------------------------------------------------
  // Statistics counters, counted on output acceptance
  // ---------------------------------------------------------------------------
`ifdef HAMM_DEC_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] corr_cnt_q,   corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

  // Clear wins over an increment landing in the same cycle.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (stat_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (out_fire) begin
      if (out_corr_q && (corr_cnt_q != CNT_MAX)) begin
        corr_cnt_d = corr_cnt_q + CNT_ONE;
      end
      if (out_uncorr_q && (uncorr_cnt_q != CNT_MAX)) begin
        uncorr_cnt_d = uncorr_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
`else
  // Counters not built: keep the clear input and accept strobe visibly unused.
  logic unused_stats;
  assign unused_stats = stat_clr ^ out_fire;
  assign corr_cnt     = '0;
  assign uncorr_cnt   = '0;
`endif

endmodule

// File: tb/tb_hamm_decoder.sv
// Purpose: self-checking bench for hamm_decoder (vector table plus handshake/reset sequences).
// Latency: checks exact 2-cycle input-to-output latency with out_ready high.
// Backpressure: random out_ready during streaming, scoreboard checks order, ready and hold.

module tb_hamm_decoder;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic [7:0]       in_code;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       out_data;
  logic             out_corr;
  logic             out_uncorr;
  logic             out_valid;
  logic             out_ready;
  logic             stat_clr;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] uncorr_cnt;

  hamm_decoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_code   (in_code),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_corr  (out_corr),
    .out_uncorr(out_uncorr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .stat_clr  (stat_clr),
    .corr_cnt  (corr_cnt),
    .uncorr_cnt(uncorr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic [3:0] data;
    logic       corr;
    logic       uncorr;
  } vec_t;

  typedef struct {
    logic [3:0] data;
    logic       corr;
    logic       uncorr;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   n_out = 0;
  int   m_corr = 0;
  int   m_uncorr = 0;
  exp_t sb[$];
  exp_t drv_exp;
  logic stall_prev = 1'b0;
  logic [6:0] prev_out = 7'h00;
  logic rnd_en = 1'b0;

  logic [7:0] clean [16];
  vec_t       vecs  [16];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard / protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      sb.delete();
      m_corr     = 0;
      m_uncorr   = 0;
      stall_prev = 1'b0;
    end else begin
`ifdef HAMM_DEC_STATS_EN
      chk("corr_cnt", 16'(corr_cnt), 16'(m_corr));
      chk("uncorr_cnt", 16'(uncorr_cnt), 16'(m_uncorr));
`else
      chk("corr_cnt_tied", 16'(corr_cnt), 16'd0);
      chk("uncorr_cnt_tied", 16'(uncorr_cnt), 16'd0);
`endif
      chk("in_ready", 16'(in_ready), 16'((sb.size() >= 2 && !out_ready) ? 0 : 1));
      if (stall_prev)
        chk("stall_hold", 16'({out_valid, out_data, out_corr, out_uncorr}), 16'(prev_out));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra: got output %0h expected none outstanding", out_data);
        end else begin
          e = sb.pop_front();
          chk("sb_data", 16'(out_data), 16'(e.data));
          chk("sb_corr", 16'(out_corr), 16'(e.corr));
          chk("sb_uncorr", 16'(out_uncorr), 16'(e.uncorr));
          n_out++;
          if (e.corr && m_corr < CNT_MAX) m_corr++;
          if (e.uncorr && m_uncorr < CNT_MAX) m_uncorr++;
        end
      end
      if (stat_clr) begin
        m_corr   = 0;
        m_uncorr = 0;
      end
      if (in_valid && in_ready) sb.push_back(drv_exp);
      stall_prev = out_valid && !out_ready;
      prev_out   = {out_valid, out_data, out_corr, out_uncorr};
    end
  end

  // Pseudo-random downstream backpressure while streaming.
  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Present one word and hold it until accepted; returns 1ns after the accepting edge.
  task automatic send(input logic [7:0] code, input exp_t e);
    bit acc;
    int n;
    @(posedge clk); #1;
    in_code  = code;
    drv_exp  = e;
    in_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: code %0h got no in_ready expected acceptance", code);
    end
  endtask

  // Word into an empty pipeline with out_ready high: valid exactly two edges later.
  task automatic lat_check(input logic [7:0] code, input logic [3:0] data);
    @(posedge clk); #1;
    in_code  = code;
    drv_exp  = '{data, 1'b0, 1'b0};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_1cyc_valid", 16'(out_valid), 16'd0);
    @(posedge clk); #1;
    chk("lat_2cyc_valid", 16'(out_valid), 16'd1);
    chk("lat_2cyc_data", 16'(out_data), 16'(data));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, 16'(sb.size()), 16'd0);
  endtask

  initial begin
    int   n;
    int   n0;
    bit   acc;
    exp_t e;

    reset    = 1'b0;
    in_code  = 8'h00;
    in_valid = 1'b0;
    out_ready = 1'b1;
    stat_clr = 1'b0;
    drv_exp  = '{4'h0, 1'b0, 1'b0};

    clean = '{8'h00, 8'h17, 8'h2B, 8'h3C, 8'h4D, 8'h5A, 8'h66, 8'h71,
              8'h8E, 8'h99, 8'hA5, 8'hB2, 8'hC3, 8'hD4, 8'hE8, 8'hFF};

    vecs[0]  = '{8'h17, 4'h1, 1'b0, 1'b0};  // clean 1
    vecs[1]  = '{8'hD4, 4'hD, 1'b0, 1'b0};  // clean D
    vecs[2]  = '{8'h97, 4'h1, 1'b1, 1'b0};  // d3 flipped
    vecs[3]  = '{8'hD5, 4'hD, 1'b1, 1'b0};  // p0 flipped
    vecs[4]  = '{8'h14, 4'h1, 1'b0, 1'b1};  // p1,p0 flipped
    vecs[5]  = '{8'h00, 4'h0, 1'b0, 1'b0};  // clean 0
    vecs[6]  = '{8'hFF, 4'hF, 1'b0, 1'b0};  // clean F
    vecs[7]  = '{8'h5E, 4'h5, 1'b1, 1'b0};  // p2 flipped
    vecs[8]  = '{8'h0D, 4'h4, 1'b1, 1'b0};  // d2 flipped
    vecs[9]  = '{8'h0B, 4'h2, 1'b1, 1'b0};  // d1 flipped
    vecs[10] = '{8'hEF, 4'hF, 1'b1, 1'b0};  // d0 flipped
    vecs[11] = '{8'h18, 4'h1, 1'b0, 1'b1};  // all four parity bits flipped
    vecs[12] = '{8'h30, 4'h3, 1'b0, 1'b1};  // d1,d0 flipped from 0x00
    vecs[13] = '{8'h0F, 4'h0, 1'b0, 1'b1};  // d3,p0 flipped from 0x8E
    vecs[14] = '{8'h86, 4'h8, 1'b1, 1'b0};  // p3 flipped
    vecs[15] = '{8'h64, 4'h6, 1'b1, 1'b0};  // p1 flipped

    // Reset state
    #12;
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_data", 16'(out_data), 16'd0);
    chk("rst_out_corr", 16'(out_corr), 16'd0);
    chk("rst_out_uncorr", 16'(out_uncorr), 16'd0);
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_corr_cnt", 16'(corr_cnt), 16'd0);
    #1 reset = 1'b1;

    // Two-cycle latency on the first words after reset
    lat_check(8'h17, 4'h1);
    lat_check(8'hD4, 4'hD);

    // Vector table, one word at a time with out_ready high
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].code, '{vecs[i].data, vecs[i].corr, vecs[i].uncorr});
      n = 0;
      while (!out_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("vec%0d_valid", i), 16'(out_valid), 16'd1);
      chk($sformatf("vec%0d_data", i), 16'(out_data), 16'(vecs[i].data));
      chk($sformatf("vec%0d_corr", i), 16'(out_corr), 16'(vecs[i].corr));
      chk($sformatf("vec%0d_uncorr", i), 16'(out_uncorr), 16'(vecs[i].uncorr));
    end
    drain("table_drain");

    // Fill both stages under backpressure, then reset mid-flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(8'h17, '{4'h1, 1'b0, 1'b0});
    send(8'hD4, '{4'hD, 1'b0, 1'b0});
    chk("full_in_ready", 16'(in_ready), 16'd0);
    chk("full_out_valid", 16'(out_valid), 16'd1);
    chk("full_out_data", 16'(out_data), 16'h1);
    #1 reset = 1'b0;
    #1;
    chk("arst_out_valid", 16'(out_valid), 16'd0);
    chk("arst_out_data", 16'(out_data), 16'd0);
    chk("arst_out_corr", 16'(out_corr), 16'd0);
    chk("arst_out_uncorr", 16'(out_uncorr), 16'd0);
    chk("arst_in_ready", 16'(in_ready), 16'd1);
    chk("arst_corr_cnt", 16'(corr_cnt), 16'd0);
    chk("arst_uncorr_cnt", 16'(uncorr_cnt), 16'd0);
    @(posedge clk); #2;
    out_ready = 1'b1;
    reset     = 1'b1;
    lat_check(8'hD4, 4'hD);
    drain("post_reset_drain");

    // Counter saturation with five corrected words
    send(vecs[2].code, '{vecs[2].data, vecs[2].corr, vecs[2].uncorr});
    send(vecs[3].code, '{vecs[3].data, vecs[3].corr, vecs[3].uncorr});
    send(vecs[7].code, '{vecs[7].data, vecs[7].corr, vecs[7].uncorr});
    send(vecs[8].code, '{vecs[8].data, vecs[8].corr, vecs[8].uncorr});
    send(vecs[9].code, '{vecs[9].data, vecs[9].corr, vecs[9].uncorr});
    drain("sat_drain");
    @(negedge clk);
`ifdef HAMM_DEC_STATS_EN
    chk("sat_corr_cnt", 16'(corr_cnt), 16'(CNT_MAX));
`else
    chk("sat_corr_cnt", 16'(corr_cnt), 16'd0);
`endif
    chk("sat_uncorr_cnt", 16'(uncorr_cnt), 16'd0);

    // stat_clr coinciding with acceptance of a corrected word
    send(8'h97, '{4'h1, 1'b1, 1'b0});
    @(posedge clk); #1;
    stat_clr = 1'b1;
    chk("clr_cycle_valid", 16'(out_valid), 16'd1);
    chk("clr_cycle_corr", 16'(out_corr), 16'd1);
    @(posedge clk); #1;
    stat_clr = 1'b0;
    chk("clr_priority", 16'(corr_cnt), 16'd0);

    // Stream all clean codewords with random backpressure
    n0 = n_out;
    rnd_en = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_code = clean[i];
      drv_exp = '{4'(i), 1'b0, 1'b0};
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 200) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        n++;
      end
      if (!acc) begin
        total++;
        bad++;
        $display("FAIL stream_timeout: word %0d got no in_ready expected acceptance", i);
      end
    end
    in_valid = 1'b0;
    rnd_en   = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain("stream_drain");
    chk("stream_count", 16'(n_out - n0), 16'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
